// File: rtl/next_pc_ctrl_pkg.sv
// Shared definitions for the next-PC controller: debug FSM state codes and
// redirect-source encoding (the debug unit decodes the same state codes).
package next_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_JR  = 2'd2,
    SRC_J   = 2'd3
  } src_e;

  // Oldest instruction wins: EX branch, then ID jr, then ID jump.
  function automatic src_e pick_src(input logic br, input logic jr, input logic j);
    if (br)      return SRC_BR;
    else if (jr) return SRC_JR;
    else if (j)  return SRC_J;
    return SRC_SEQ;
  endfunction

endpackage

// File: rtl/next_pc_ctrl_if.sv
// Bus between the IF-stage next-PC controller and its redirect/debug sources.
// The slave side is the controller; the master side drives the requests.
interface next_pc_ctrl_if #(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 32
);
  logic [NBITS-1:0]   i_PC;
  logic               i_stall;
  logic               i_branch_taken;
  logic [NBITS-1:0]   i_branch_target;
  logic               i_jump;
  logic               i_jr;
  logic [NBITS-1:0]   i_jump_target;
  logic               i_halt_instr;
  logic               i_dbg_run;
  logic               i_dbg_step;
  logic [NBITS-1:0]   o_NPC;
  logic               o_flush_IF;
  logic               o_halted;
  logic [CNTBITS-1:0] o_adv_count;

  modport master (
    output i_PC, i_stall, i_branch_taken, i_branch_target, i_jump, i_jr,
           i_jump_target, i_halt_instr, i_dbg_run, i_dbg_step,
    input  o_NPC, o_flush_IF, o_halted, o_adv_count
  );

  modport slave (
    input  i_PC, i_stall, i_branch_taken, i_branch_target, i_jump, i_jr,
           i_jump_target, i_halt_instr, i_dbg_run, i_dbg_step,
    output o_NPC, o_flush_IF, o_halted, o_adv_count
  );
endinterface

// File: rtl/next_pc_ctrl_redirect_latch.sv
// Holds one redirect that arrived while the PC was frozen, so it is applied
// on the next advance. A held jump may be replaced by a (older) branch only.
module npc_redirect_latch
  import next_pc_ctrl_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  src_e             i_src,
  input  logic [NBITS-1:0] i_target,
  output logic             o_valid,
  output logic [NBITS-1:0] o_target,
  output logic             o_is_branch
);
  logic             r_valid;
  logic             r_is_branch;
  logic [NBITS-1:0] r_target;
  logic             w_accept;

  assign w_accept = (i_src != SRC_SEQ) &&
                    (!r_valid || ((i_src == SRC_BR) && !r_is_branch));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_valid     <= 1'b0;
      r_is_branch <= 1'b0;
    end else if (i_clear) begin
      r_valid     <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_is_branch <= (i_src == SRC_BR);
    end
  end

  // NOTE: the target is data qualified by r_valid, so it needs no reset;
  // keeping it out of the reset branch avoids a reset mux on every bit.
  always_ff @(posedge i_clk) begin
    if (!i_clear && w_accept) r_target <= i_target;
  end

  assign o_valid     = r_valid;
  assign o_target    = r_target;
  assign o_is_branch = r_is_branch;
endmodule

// File: rtl/next_pc_ctrl.sv
// IF-stage next-PC producer: target mux, hazard hold, pending redirect and
// the debug run/step/halt FSM. o_NPC = i_PC holds the (enable-less) PC register.
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int PC_INC  = 4,
  parameter int CNTBITS = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  next_pc_ctrl_if.slave  bus
);
  state_e             r_state;
  logic               r_halted;
  logic [CNTBITS-1:0] r_adv_count;

  src_e               w_live_src;
  logic [NBITS-1:0]   w_live_raw;
  logic [NBITS-1:0]   w_live_target;
  logic               w_adv;
  logic               w_pend_valid;
  logic [NBITS-1:0]   w_pend_target;
  logic               w_pend_is_branch;
  logic [NBITS-1:0]   w_npc;
  logic               w_flush;

  assign w_live_src    = pick_src(bus.i_branch_taken, bus.i_jr, bus.i_jump);
  assign w_live_raw    = (w_live_src == SRC_BR) ? bus.i_branch_target : bus.i_jump_target;
  assign w_live_target = {w_live_raw[NBITS-1:2], 2'b00};

  assign w_adv = i_reset && ((r_state == S_RUN) || (r_state == S_STEP)) &&
                 !bus.i_stall && !bus.i_halt_instr;

  npc_redirect_latch #(.NBITS(NBITS)) u_pending (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_adv),
    .i_src       (w_live_src),
    .i_target    (w_live_target),
    .o_valid     (w_pend_valid),
    .o_target    (w_pend_target),
    .o_is_branch (w_pend_is_branch)
  );

  // NOTE: every output gets a default before the ifs; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_npc   = bus.i_PC;
    w_flush = 1'b0;
    if (w_adv) begin
      if (w_live_src != SRC_SEQ) begin
        w_npc   = w_live_target;
        w_flush = 1'b1;
      end else if (w_pend_valid) begin
        w_npc   = w_pend_target;
        w_flush = 1'b1;
      end else begin
        w_npc   = bus.i_PC + NBITS'(PC_INC);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_halted    <= 1'b0;
      r_adv_count <= '0;
    end else begin
      if (w_adv) r_adv_count <= r_adv_count + CNTBITS'(1);
      case (r_state)
        S_IDLE: begin
          if (bus.i_dbg_run)       r_state <= S_RUN;
          else if (bus.i_dbg_step) r_state <= S_STEP;
        end
        S_RUN: begin
          if (bus.i_halt_instr && !bus.i_stall) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_STEP: begin
          if (bus.i_halt_instr) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_adv) begin
            r_state  <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_NPC       = w_npc;
  assign bus.o_flush_IF  = w_flush;
  assign bus.o_halted    = r_halted;
  assign bus.o_adv_count = r_adv_count;

  logic w_unused;
  assign w_unused = w_pend_is_branch;
endmodule

// File: tb/tb_next_pc_ctrl.sv
// Scoreboard bench for next_pc_ctrl: a behavioural model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_next_pc_ctrl;
  localparam int NBITS   = 32;
  localparam int PC_INC  = 4;
  localparam int CNTBITS = 4;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        jr;
    logic        j;
    logic [31:0] j_t;
    logic        halt;
    logic        run;
    logic        step;
  } stim_t;

  typedef struct {
    logic [31:0] npc;
    logic        flush;
    logic        halted;
    logic [31:0] cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  next_pc_ctrl_if #(.NBITS(NBITS), .CNTBITS(CNTBITS)) bus ();

  next_pc_ctrl #(.NBITS(NBITS), .PC_INC(PC_INC), .CNTBITS(CNTBITS)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] pc      = 32'h0;

  // Behavioural model: mode flags, pending redirect, advance count.
  bit          m_run, m_step, m_halted;
  bit          m_pv, m_pbr;
  logic [31:0] m_pt;
  int unsigned m_count;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("npc",       e.cyc, bus.o_NPC,                e.npc);
      check("flush_IF",  e.cyc, 32'(bus.o_flush_IF),      32'(e.flush));
      check("halted",    e.cyc, 32'(bus.o_halted),        32'(e.halted));
      check("adv_count", e.cyc, 32'(bus.o_adv_count),     e.cnt);
    end
  end

  function automatic stim_t quiet();
    stim_t s;
    s.rst_n = 1'b1; s.stall = 1'b0; s.br = 1'b0; s.br_t = '0; s.jr = 1'b0;
    s.j = 1'b0; s.j_t = '0; s.halt = 1'b0; s.run = 1'b0; s.step = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t        e;
    bit          moving, live;
    logic [31:0] lt;
    rst_n               = s.rst_n;
    bus.i_PC            = pc;
    bus.i_stall         = s.stall;
    bus.i_branch_taken  = s.br;
    bus.i_branch_target = s.br_t;
    bus.i_jr            = s.jr;
    bus.i_jump          = s.j;
    bus.i_jump_target   = s.j_t;
    bus.i_halt_instr    = s.halt;
    bus.i_dbg_run       = s.run;
    bus.i_dbg_step      = s.step;

    moving = s.rst_n && (m_run || m_step) && !s.stall && !s.halt;
    live   = s.br || s.jr || s.j;
    lt     = (s.br ? s.br_t : s.j_t) & 32'hFFFF_FFFC;

    e.npc   = pc;
    e.flush = 1'b0;
    if (moving) begin
      if (live)      begin e.npc = lt;   e.flush = 1'b1; end
      else if (m_pv) begin e.npc = m_pt; e.flush = 1'b1; end
      else           e.npc = pc + 32'(PC_INC);
    end
    e.halted = m_halted;
    e.cnt    = m_count;
    e.cyc    = cyc;
    sb_q.push_back(e);

    if (!s.rst_n) begin
      m_run = 0; m_step = 0; m_halted = 0; m_pv = 0; m_pbr = 0; m_count = 0;
    end else begin
      if (moving) begin
        m_count = (m_count + 1) % (1 << CNTBITS);
        m_pv    = 0;
      end else if (live && (!m_pv || (s.br && !m_pbr))) begin
        m_pv = 1; m_pt = lt; m_pbr = s.br;
      end
      if (m_halted) begin
      end else if (m_run) begin
        if (s.halt && !s.stall) begin m_halted = 1; m_run = 0; end
      end else if (m_step) begin
        if (s.halt)      begin m_halted = 1; m_step = 0; end
        else if (moving) m_step = 0;
      end else begin
        if (s.run)       m_run  = 1;
        else if (s.step) m_step = 1;
      end
    end

    pc = s.rst_n ? e.npc : 32'h0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    m_run = 0; m_step = 0; m_halted = 0; m_pv = 0; m_pbr = 0; m_pt = '0; m_count = 0;
    s = quiet(); s.rst_n = 1'b0;
    rst_n = 1'b0;
    bus.i_PC = '0; bus.i_stall = 0; bus.i_branch_taken = 0; bus.i_branch_target = '0;
    bus.i_jr = 0; bus.i_jump = 0; bus.i_jump_target = '0; bus.i_halt_instr = 0;
    bus.i_dbg_run = 0; bus.i_dbg_step = 0;
    @(posedge clk); #1;

    // Reset, free run from PC 0: 0x4, 0x8, 0xC.
    apply(s);
    s = quiet(); s.run = 1; apply(s);
    s = quiet(); repeat (4) apply(s);

    // Branch beats a simultaneous jump; target alignment.
    pc = 32'h40;
    s = quiet(); s.br = 1; s.br_t = 32'h103; s.j = 1; s.j_t = 32'h200; apply(s);

    // Jump during stall is held and applied on release.
    pc = 32'h20;
    s = quiet(); s.stall = 1; s.j = 1; s.j_t = 32'h80; apply(s);
    s = quiet(); s.stall = 1; apply(s); apply(s);
    s = quiet(); apply(s); apply(s);

    // Single step, then a step delayed by stall.
    s = quiet(); s.rst_n = 0; apply(s);
    pc = 32'h10;
    s = quiet(); s.step = 1; apply(s);
    s = quiet(); apply(s); apply(s); apply(s);
    s = quiet(); s.step = 1; apply(s);
    s = quiet(); s.stall = 1; apply(s); apply(s);
    s = quiet(); apply(s); apply(s);

    // Halt, ignored debug pulses, reset out of halt.
    s = quiet(); s.run = 1; apply(s);
    pc = 32'h30;
    s = quiet(); s.halt = 1; apply(s);
    s = quiet(); s.run = 1; s.step = 1; apply(s); apply(s);
    s = quiet(); apply(s);
    s = quiet(); s.rst_n = 0; apply(s);
    s = quiet(); apply(s);

    // Sequential wrap at top of address space, then counter wrap.
    s = quiet(); s.run = 1; apply(s);
    pc = 32'hFFFF_FFFC;
    s = quiet(); repeat (18) apply(s);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      s = quiet();
      s.rst_n = ($urandom_range(63) != 0);
      s.stall = ($urandom_range(3) == 0);
      s.br    = ($urandom_range(5) == 0);
      s.br_t  = $urandom();
      s.jr    = ($urandom_range(7) == 0);
      s.j     = ($urandom_range(5) == 0);
      s.j_t   = $urandom();
      s.halt  = ($urandom_range(39) == 0);
      s.run   = ($urandom_range(7) == 0);
      s.step  = ($urandom_range(7) == 0);
      apply(s);
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", cyc, 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
